// File: rtl/prog_moore_seq_detector_if.sv
// Bit-stream, config and status bundle for the programmable detector.
// The detector takes the slave side; the stimulus source takes the master side.
interface prog_moore_seq_detector_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic               x;
  logic               x_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               count_clr;
  logic               z;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  modport master (
    output x, x_valid, cfg_load, cfg_pattern,
    output cfg_len, cfg_overlap, count_clr,
    input  z, match_count, cfg_err
  );

  modport slave (
    input  x, x_valid, cfg_load, cfg_pattern,
    input  cfg_len, cfg_overlap, count_clr,
    output z, match_count, cfg_err
  );
endinterface

// File: rtl/prog_moore_seq_detector.sv
// Runtime-programmable Moore sequence detector with saturating match counter.
// z and all status outputs are registered; there is no path from x to z.
module prog_moore_seq_detector #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN =
    MAX_LEN'(8'b0000_1101),
  parameter int DEFAULT_LEN = 4,
  parameter bit DEFAULT_OVERLAP = 1'b1
) (
  input logic clk,
  input logic reset,
  prog_moore_seq_detector_if.slave bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] DEF_L = LEN_W'(DEFAULT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               z_q, z_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] hist_sh;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_inc;
  logic [CNT_W-1:0]   cnt_base;
  logic               cfg_ok;
  logic               accept;
  logic               hit;

  // Compare the would-be history against the active pattern slice.
  always_comb begin
    hist_sh  = {hist_q[MAX_LEN-2:0], bus.x};
    fill_inc = (fill_q == MAX_L) ? fill_q : fill_q + 1'b1;
    mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
    cfg_ok = (bus.cfg_len != '0) && (bus.cfg_len <= MAX_L);
    accept = bus.x_valid && !bus.cfg_load;
    hit    = accept && (fill_inc >= len_q) &&
             (((hist_sh ^ pat_q) & mask) == '0);
  end

  // Next-state: config load wins over the bit stream.
  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    z_d    = z_q;
    err_d  = bus.cfg_load && !cfg_ok;
    if (bus.cfg_load) begin
      if (cfg_ok) begin
        pat_d  = bus.cfg_pattern;
        len_d  = bus.cfg_len;
        ovl_d  = bus.cfg_overlap;
        hist_d = '0;
        fill_d = '0;
        z_d    = 1'b0;
      end
    end else if (bus.x_valid) begin
      hist_d = hist_sh;
      fill_d = (hit && !ovl_q) ? '0 : fill_inc;
      z_d    = hit;
    end
    cnt_base = bus.count_clr ? '0 : cnt_q;
    if (hit && cnt_base != CNT_MAX) begin
      cnt_d = cnt_base + 1'b1;
    end else begin
      cnt_d = cnt_base;
    end
  end

  // State registers; reset restores the default configuration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q  <= DEFAULT_PATTERN;
      len_q  <= DEF_L;
      ovl_q  <= DEFAULT_OVERLAP;
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q    <= z_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign bus.z           = z_q;
  assign bus.match_count = cnt_q;
  assign bus.cfg_err     = err_q;

endmodule

// File: tb/tb_prog_moore_seq_detector.sv
// Directed bench for prog_moore_seq_detector.
// Instance a: default widths; instance b: CNT_W=2 for saturation.
module tb_prog_moore_seq_detector;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  prog_moore_seq_detector_if #(.MAX_LEN(8), .CNT_W(8)) ia ();
  prog_moore_seq_detector_if #(.MAX_LEN(8), .CNT_W(2)) ib ();

  prog_moore_seq_detector #(.MAX_LEN(8), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .bus(ia.slave)
  );
  prog_moore_seq_detector #(.MAX_LEN(8), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .bus(ib.slave)
  );

  task automatic bit_a(input logic b);
    ia.x = b;
    ia.x_valid = 1'b1;
    @(posedge clk);
    #1;
    ia.x_valid = 1'b0;
  endtask

  task automatic bit_b(input logic b, input logic clr);
    ib.x = b;
    ib.x_valid = 1'b1;
    ib.count_clr = clr;
    @(posedge clk);
    #1;
    ib.x_valid = 1'b0;
    ib.count_clr = 1'b0;
  endtask

  task automatic idle_a(input logic xv);
    ia.x = xv;
    ia.x_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_a(input logic [7:0] p, input logic [3:0] l,
                       input logic o, input logic clr);
    ia.cfg_load = 1'b1;
    ia.cfg_pattern = p;
    ia.cfg_len = l;
    ia.cfg_overlap = o;
    ia.count_clr = clr;
    ia.x = 1'b1;
    ia.x_valid = 1'b1;
    @(posedge clk);
    #1;
    ia.cfg_load = 1'b0;
    ia.count_clr = 1'b0;
    ia.x_valid = 1'b0;
  endtask

  task automatic test_reset;
    if (ia.z !== 1'b0) begin
      fails++;
      $display("FAIL rst_z_a got %b exp 0", ia.z);
    end
    tests++;
    if (ia.match_count !== 8'd0) begin
      fails++;
      $display("FAIL rst_cnt_a got %0d exp 0", ia.match_count);
    end
    tests++;
    if (ia.cfg_err !== 1'b0) begin
      fails++;
      $display("FAIL rst_err_a got %b exp 0", ia.cfg_err);
    end
    tests++;
    if (ib.match_count !== 2'd0) begin
      fails++;
      $display("FAIL rst_cnt_b got %0d exp 0", ib.match_count);
    end
    tests++;
  endtask

  task automatic test_overlap;
    logic [15:0] s;
    logic e;
    s = 16'b1101011011010110;
    for (int i = 0; i < 16; i++) begin
      bit_a(s[15-i]);
      e = (i == 3) || (i == 8) || (i == 11);
      if (ia.z !== e) begin
        fails++;
        $display("FAIL ovl_z[%0d] got %b exp %b", i, ia.z, e);
      end
      tests++;
    end
    if (ia.match_count !== 8'd3) begin
      fails++;
      $display("FAIL ovl_cnt got %0d exp 3", ia.match_count);
    end
    tests++;
  endtask

  task automatic test_no_overlap;
    logic [15:0] s;
    logic e;
    s = 16'b1101011011010110;
    cfg_a(8'b0000_1101, 4'd4, 1'b0, 1'b1);
    if (ia.match_count !== 8'd0 || ia.z !== 1'b0) begin
      fails++;
      $display("FAIL novl_load got z=%b cnt=%0d exp z=0 cnt=0",
               ia.z, ia.match_count);
    end
    tests++;
    for (int i = 0; i < 16; i++) begin
      bit_a(s[15-i]);
      e = (i == 3) || (i == 8);
      if (ia.z !== e) begin
        fails++;
        $display("FAIL novl_z[%0d] got %b exp %b", i, ia.z, e);
      end
      tests++;
    end
    if (ia.match_count !== 8'd2) begin
      fails++;
      $display("FAIL novl_cnt got %0d exp 2", ia.match_count);
    end
    tests++;
  endtask

  task automatic test_idle_gap;
    logic [2:0] s;
    s = 3'b110;
    cfg_a(8'b0000_1101, 4'd4, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bit_a(s[2-i]);
      if (ia.z !== 1'b0) begin
        fails++;
        $display("FAIL gap_pre[%0d] got %b exp 0", i, ia.z);
      end
      tests++;
    end
    for (int i = 0; i < 5; i++) begin
      idle_a(i[0]);
      if (ia.z !== 1'b0) begin
        fails++;
        $display("FAIL gap_idle[%0d] got %b exp 0", i, ia.z);
      end
      tests++;
    end
    bit_a(1'b1);
    if (ia.z !== 1'b1) begin
      fails++;
      $display("FAIL gap_hit got %b exp 1", ia.z);
    end
    tests++;
    for (int i = 0; i < 3; i++) begin
      idle_a(1'b0);
      if (ia.z !== 1'b1) begin
        fails++;
        $display("FAIL gap_hold[%0d] got %b exp 1", i, ia.z);
      end
      tests++;
    end
    if (ia.match_count !== 8'd1) begin
      fails++;
      $display("FAIL gap_cnt got %0d exp 1", ia.match_count);
    end
    tests++;
  endtask

  task automatic test_cfg_err;
    logic [3:0] bad [2];
    logic [3:0] s;
    logic e;
    bad[0] = 4'd0;
    bad[1] = 4'd9;
    for (int k = 0; k < 2; k++) begin
      cfg_a(8'hFF, bad[k], 1'b0, 1'b0);
      if (ia.cfg_err !== 1'b1) begin
        fails++;
        $display("FAIL err_pulse[%0d] got %b exp 1", k, ia.cfg_err);
      end
      tests++;
      if (ia.z !== 1'b1) begin
        fails++;
        $display("FAIL err_keep_z[%0d] got %b exp 1", k, ia.z);
      end
      tests++;
      idle_a(1'b0);
      if (ia.cfg_err !== 1'b0) begin
        fails++;
        $display("FAIL err_end[%0d] got %b exp 0", k, ia.cfg_err);
      end
      tests++;
    end
    s = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      bit_a(s[3-i]);
      e = (i == 3);
      if (ia.z !== e) begin
        fails++;
        $display("FAIL err_det[%0d] got %b exp %b", i, ia.z, e);
      end
      tests++;
    end
    if (ia.match_count !== 8'd2) begin
      fails++;
      $display("FAIL err_cnt got %0d exp 2", ia.match_count);
    end
    tests++;
  endtask

  task automatic test_saturate;
    logic [1:0] exp_c [6];
    exp_c[0] = 2'd1;
    exp_c[1] = 2'd2;
    exp_c[2] = 2'd3;
    exp_c[3] = 2'd3;
    exp_c[4] = 2'd3;
    exp_c[5] = 2'd3;
    ib.cfg_load = 1'b1;
    ib.cfg_pattern = 8'b1111_1101;
    ib.cfg_len = 4'd1;
    ib.cfg_overlap = 1'b1;
    @(posedge clk);
    #1;
    ib.cfg_load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bit_b(1'b1, 1'b0);
      if (ib.match_count !== exp_c[i] || ib.z !== 1'b1) begin
        fails++;
        $display("FAIL sat[%0d] got cnt=%0d z=%b exp cnt=%0d z=1",
                 i, ib.match_count, ib.z, exp_c[i]);
      end
      tests++;
    end
    bit_b(1'b1, 1'b1);
    if (ib.match_count !== 2'd1) begin
      fails++;
      $display("FAIL sat_clr got %0d exp 1", ib.match_count);
    end
    tests++;
    bit_b(1'b0, 1'b0);
    if (ib.z !== 1'b0 || ib.match_count !== 2'd1) begin
      fails++;
      $display("FAIL sat_zero got z=%b cnt=%0d exp z=0 cnt=1",
               ib.z, ib.match_count);
    end
    tests++;
  endtask

  task automatic test_async_reset;
    logic [2:0] s;
    s = 3'b110;
    for (int i = 0; i < 3; i++) bit_a(s[2-i]);
    #2;
    reset = 1'b1;
    #1;
    if (ia.z !== 1'b0 || ia.match_count !== 8'd0) begin
      fails++;
      $display("FAIL arst_now got z=%b cnt=%0d exp z=0 cnt=0",
               ia.z, ia.match_count);
    end
    tests++;
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    bit_a(1'b1);
    if (ia.z !== 1'b0 || ia.match_count !== 8'd0) begin
      fails++;
      $display("FAIL arst_tail got z=%b cnt=%0d exp z=0 cnt=0",
               ia.z, ia.match_count);
    end
    tests++;
  endtask

  initial begin
    ia.x = 1'b0;
    ia.x_valid = 1'b0;
    ia.cfg_load = 1'b0;
    ia.cfg_pattern = '0;
    ia.cfg_len = '0;
    ia.cfg_overlap = 1'b0;
    ia.count_clr = 1'b0;
    ib.x = 1'b0;
    ib.x_valid = 1'b0;
    ib.cfg_load = 1'b0;
    ib.cfg_pattern = '0;
    ib.cfg_len = '0;
    ib.cfg_overlap = 1'b0;
    ib.count_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_overlap();
    test_no_overlap();
    test_idle_gap();
    test_cfg_err();
    test_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prog_moore_seq_detector.md
Name: prog_moore_seq_detector

Overview:
Runtime-programmable Moore sequence detector for a serial bit stream. Pattern, pattern length and overlap mode are loaded through a config port, and a saturating match counter is included. It is the parametrised successor to the fixed-pattern Moore detector and is used where several protocol preambles share one detector instance.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32)
CNT_W, 8, width of the match counter
DEFAULT_PATTERN, 8'b0000_1101, pattern after reset, right-aligned
DEFAULT_LEN, 4, pattern length after reset
DEFAULT_OVERLAP, 1, overlap mode after reset (1 = overlapping)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
x  in  1  serial input bit
x_valid  in  1  x is consumed on a rising edge only when this is 1
cfg_load  in  1  load the cfg_* inputs on this edge
cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is received first, bit [0] last
cfg_len  in  $clog2(MAX_LEN+1)  pattern length; legal range 1..MAX_LEN
cfg_overlap  in  1  1 = overlapping detection, 0 = restart after a match
count_clr  in  1  synchronous clear of match_count
z  out  1  Moore detect output, registered
match_count  out  CNT_W  number of matches, saturating
cfg_err  out  1  one-cycle pulse when cfg_load carries an illegal length

Behaviour:
- Reset (asynchronous):
  - pattern/len/overlap take their DEFAULT_* values.
  - History register, fill counter, z, match_count and cfg_err all go to 0.
- State: hist[MAX_LEN-1:0] shift register and fill = number of bits accepted since the last restart, saturating at MAX_LEN.
- Accepted bit (x_valid=1, cfg_load=0):
  - hist <= {hist[MAX_LEN-2:0], x}; fill increments.
  - Match condition, evaluated on the updated values: fill >= len and hist[len-1:0] == pattern[len-1:0].
- z is a pure function of the registered state (Moore).
  - It goes high on the edge that accepts the completing bit, so it is visible in the following cycle.
  - It stays high until the next accepted bit or a restart. Idle cycles (x_valid=0) hold z.
  - Latency from the completing bit being sampled to z=1: one edge. Combinational x-to-z paths are forbidden.
- Overlap=1: after a match, hist and fill are retained, so the next match may share bits.
- Overlap=0: on the matching edge, fill resets to 0 and z is set to 1. The next match needs len fresh bits.
- match_count increments on every matching edge and saturates at 2^CNT_W-1 (no wrap).
- count_clr:
  - Clears match_count on that edge.
  - If a match occurs on the same edge, match_count = 1.
  - Does not affect z or hist.
- cfg_load with 1 <= cfg_len <= MAX_LEN:
  - Latches pattern, len and overlap.
  - Clears hist, fill and z. match_count is untouched.
  - x on that edge is discarded, even if x_valid=1.
- cfg_load with cfg_len = 0 or cfg_len > MAX_LEN:
  - Old config is kept and history is not disturbed.
  - cfg_err = 1 for exactly the next cycle.
  - x is still discarded on that edge.
- Pattern bits above len-1 are ignored in the compare.
- len = 1: z follows every accepted bit equal to pattern[0].
- Reset asserted mid-stream: everything returns to its reset value immediately. No match is counted for the partial sequence.

Test Plan:
1. Default config (1101, overlap). After reset, feed 1101011011010110 MSB-first, one bit per cycle, x_valid=1 throughout.
   -> z high in the cycles after bits 3, 8 and 11 (0-indexed); match_count = 3.
2. Same stream after cfg_load with pattern=1101, len=4, overlap=0.
   -> z high only after bits 3 and 8; match_count = 2.
3. Feed 110, hold x_valid=0 for 5 cycles with x toggling, then feed 1.
   -> No match during the gap; z rises one edge after the final 1 and holds through a further 3 idle cycles.
4. cfg_load with cfg_len=0, then cfg_len=9 (MAX_LEN=8).
   -> cfg_err pulses one cycle each; 1101 is still detected afterwards.
5. CNT_W=2, len=1, pattern=1, feed six 1s.
   -> match_count = 1, 2, 3, 3, 3, 3.
   -> count_clr together with a seventh 1 gives match_count = 1.
6. Assert reset asynchronously between edges after 110 of 1101, release it, then feed 1.
   -> z = 0 and match_count = 0 immediately; the trailing 1 produces no match.
